// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared types for the instruction/data memory port arbiter.
//                Requester IDs, the response-ID FIFO entry and the lock
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    // One outstanding transaction: who asked, and whether its response
    // must be swallowed because the fetch stream was flushed.
    typedef struct packed {
        req_id_e id;
        logic    discard;
    } out_entry_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage
`default_nettype wire

// File: rtl/resp_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : resp_id_fifo
//  Description : Circular FIFO holding the requester ID of every granted but
//                unanswered memory transaction. A flush marks every INSTR
//                entry as discard in place.
//  Ports       : clk, rst          - clock, async active-high reset
//                push_i/push_entry_i - enqueue one entry
//                pop_i             - dequeue the head
//                flush_i           - set discard on all INSTR entries
//                head_o            - current head entry
//                count_o/full_o/empty_o - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_id_fifo
    import mem_bus_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  out_entry_t       push_entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output out_entry_t       head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    out_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_push;
    logic             w_pop;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{id: REQ_INSTR, discard: 1'b0};
            end
        end else begin
            // Marking free slots too is harmless: they are overwritten on push.
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem_q[i].id == REQ_INSTR) begin
                        mem_q[i].discard <= 1'b1;
                    end
                end
            end
            // The pushed entry already carries its own discard bit, so the
            // later assignment correctly overrides the flush mark.
            if (w_push) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one req/gnt/rvalid memory port between the fetch
//                stage and the load/store unit. Data wins by default, with a
//                starvation limit for fetch; an ungranted request locks the
//                selection. In-order responses are routed back using a FIFO
//                of requester IDs; flushed fetch responses are dropped.
//  Ports       : instr_*  - fetch requester (req/addr/gnt/rvalid/rdata/err,
//                           flush)
//                data_*   - load/store requester
//                mem_*    - single memory port
//                busy_o   - transactions outstanding
//                unexpected_rvalid_o - sticky, response with nothing pending
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        instr_flush_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        busy_o,
    output logic        unexpected_rvalid_o
);

    localparam int         CNT_W          = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    lock_state_e      lock_q, lock_d;
    req_id_e          sel_q, sel_d;
    req_id_e          w_sel;
    logic [3:0]       starve_q, starve_d;
    logic             unexpected_q;
    out_entry_t       w_head;
    out_entry_t       w_push_entry;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_gnt;
    logic             w_pop;
    logic             w_head_drop;

    // ---------------- selection ----------------
    always_comb begin
        w_sel = REQ_DATA;
        if (lock_q == LOCKED) begin
            w_sel = sel_q;
        end else if (instr_req_i && (!data_req_i || starve_q == C_STARVE_LIMIT)) begin
            w_sel = REQ_INSTR;
        end
    end

    // A full FIFO blocks the request even if a pop happens this cycle; the
    // count is registered, so the unblock is seen one cycle later.
    assign mem_req_o   = (instr_req_i | data_req_i) & ~w_full;
    assign w_gnt       = mem_gnt_i & mem_req_o;
    assign instr_gnt_o = w_gnt & (w_sel == REQ_INSTR);
    assign data_gnt_o  = w_gnt & (w_sel == REQ_DATA);

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (mem_req_o) begin
            if (w_sel == REQ_INSTR) begin
                mem_be_o   = BE_WORD;
                mem_addr_o = instr_addr_i;
            end else begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end
        end
    end

    // ---------------- lock FSM ----------------
    always_comb begin
        lock_d = lock_q;
        sel_d  = sel_q;
        case (lock_q)
            UNLOCKED: begin
                if (mem_req_o && !mem_gnt_i) begin
                    lock_d = LOCKED;
                    sel_d  = w_sel;
                end
            end
            LOCKED: begin
                if (w_gnt) begin
                    lock_d = UNLOCKED;
                end
            end
            default: lock_d = UNLOCKED;
        endcase
    end

    // ---------------- starvation counter ----------------
    always_comb begin
        starve_d = starve_q;
        if (!instr_req_i || instr_gnt_o) begin
            starve_d = 4'h0;
        end else if (data_gnt_o && starve_q != C_STARVE_LIMIT) begin
            starve_d = starve_q + 4'h1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q       <= UNLOCKED;
            sel_q        <= REQ_DATA;
            starve_q     <= 4'h0;
            unexpected_q <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            sel_q    <= sel_d;
            starve_q <= starve_d;
            if (mem_rvalid_i && w_empty) begin
                unexpected_q <= 1'b1;
            end
        end
    end

    // ---------------- response ID tracking ----------------
    assign w_push_entry = '{id: w_sel, discard: (w_sel == REQ_INSTR) & instr_flush_i};
    assign w_pop        = mem_rvalid_i & ~w_empty;

    resp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_id_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (w_gnt),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .flush_i      (instr_flush_i),
        .head_o       (w_head),
        .count_o      (w_count),
        .full_o       (w_full),
        .empty_o      (w_empty)
    );

    // A flush in the same cycle as the head pops must also kill that response.
    assign w_head_drop    = w_head.discard | instr_flush_i;
    assign data_rvalid_o  = w_pop & (w_head.id == REQ_DATA);
    assign instr_rvalid_o = w_pop & (w_head.id == REQ_INSTR) & ~w_head_drop;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : 32'h0;
    assign data_err_o     = data_rvalid_o  & mem_err_i;
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;

    assign busy_o              = (w_count != '0);
    assign unexpected_rvalid_o = unexpected_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter: directed vector
//                table, hand-written reset/unexpected sequences, and random
//                traffic checked against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MAXO  = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_i, instr_flush_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        busy_o, unexpected_rvalid_o;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (LIMIT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr_req_i         (instr_req_i),
        .instr_addr_i        (instr_addr_i),
        .instr_gnt_o         (instr_gnt_o),
        .instr_rvalid_o      (instr_rvalid_o),
        .instr_rdata_o       (instr_rdata_o),
        .instr_err_o         (instr_err_o),
        .instr_flush_i       (instr_flush_i),
        .data_req_i          (data_req_i),
        .data_we_i           (data_we_i),
        .data_be_i           (data_be_i),
        .data_addr_i         (data_addr_i),
        .data_wdata_i        (data_wdata_i),
        .data_gnt_o          (data_gnt_o),
        .data_rvalid_o       (data_rvalid_o),
        .data_rdata_o        (data_rdata_o),
        .data_err_o          (data_err_o),
        .mem_req_o           (mem_req_o),
        .mem_we_o            (mem_we_o),
        .mem_be_o            (mem_be_o),
        .mem_addr_o          (mem_addr_o),
        .mem_wdata_o         (mem_wdata_o),
        .mem_gnt_i           (mem_gnt_i),
        .mem_rvalid_i        (mem_rvalid_i),
        .mem_rdata_i         (mem_rdata_i),
        .mem_err_i           (mem_err_i),
        .busy_o              (busy_o),
        .unexpected_rvalid_o (unexpected_rvalid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        logic [141:0] v;
        v = {instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o, data_gnt_o,
             data_rvalid_o, data_rdata_o, data_err_o, mem_req_o, mem_we_o, mem_be_o,
             mem_addr_o, mem_wdata_o, busy_o, unexpected_rvalid_o};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s all-outputs: got %h expected 0", tag, v);
        end
    endtask

    task automatic idle_inputs();
        instr_req_i = 0; instr_addr_i = 0; instr_flush_i = 0;
        data_req_i = 0; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 0; data_wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic        mg;
        logic        rv;
        logic [31:0] rd;
        logic        fl;
        logic        e_ig, e_dg, e_irv, e_drv, e_mreq;
        logic [31:0] e_maddr;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic [31:0] da, input logic mg, input logic rv,
                                input logic [31:0] rd, input logic fl, input logic e_ig,
                                input logic e_dg, input logic e_irv, input logic e_drv,
                                input logic e_mreq, input logic [31:0] e_maddr,
                                input logic e_busy);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.mg = mg; v.rv = rv; v.rd = rd;
        v.fl = fl; v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv; v.e_drv = e_drv;
        v.e_mreq = e_mreq; v.e_maddr = e_maddr; v.e_busy = e_busy;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { bit is_instr; bit disc; } ent_t;
    ent_t q[$];
    bit   m_locked, m_owner_instr, m_unexp, last_ig, last_dg;
    int   m_starve;

    task automatic model_reset();
        q.delete();
        m_locked = 0; m_owner_instr = 0; m_unexp = 0; m_starve = 0;
        last_ig = 0; last_dg = 0;
    endtask

    task automatic model_check_step();
        bit full, req, sel_i, gnt, ig, dg, irv, drv, uex;
        full  = (q.size() == MAXO);
        req   = (instr_req_i || data_req_i) && !full;
        sel_i = m_locked ? m_owner_instr
                         : (instr_req_i && (!data_req_i || m_starve == LIMIT));
        gnt = req && mem_gnt_i;
        ig  = gnt && sel_i;
        dg  = gnt && !sel_i;
        irv = 0; drv = 0; uex = m_unexp;
        if (mem_rvalid_i) begin
            if (q.size() == 0) uex = 1;
            else if (!q[0].is_instr) drv = 1;
            else if (!q[0].disc && !instr_flush_i) irv = 1;
        end
        chk("rnd mem_req", mem_req_o, req);
        chk("rnd instr_gnt", instr_gnt_o, ig);
        chk("rnd data_gnt", data_gnt_o, dg);
        if (req) begin
            chk("rnd mem_addr", mem_addr_o, sel_i ? instr_addr_i : data_addr_i);
            chk("rnd mem_we", mem_we_o, sel_i ? 1'b0 : data_we_i);
            chk("rnd mem_be", mem_be_o, sel_i ? 4'hF : data_be_i);
            chk("rnd mem_wdata", mem_wdata_o, sel_i ? 32'h0 : data_wdata_i);
        end
        chk("rnd instr_rvalid", instr_rvalid_o, irv);
        chk("rnd data_rvalid", data_rvalid_o, drv);
        chk("rnd instr_rdata", instr_rdata_o, irv ? mem_rdata_i : 32'h0);
        chk("rnd data_rdata", data_rdata_o, drv ? mem_rdata_i : 32'h0);
        if (irv) chk("rnd instr_err", instr_err_o, mem_err_i);
        if (drv) chk("rnd data_err", data_err_o, mem_err_i);
        chk("rnd busy", busy_o, q.size() != 0);
        chk("rnd unexpected", unexpected_rvalid_o, m_unexp);
        // advance model to the state after the coming clock edge
        m_unexp = uex;
        if (mem_rvalid_i && q.size() > 0) q.delete(0);
        if (instr_flush_i) foreach (q[i]) if (q[i].is_instr) q[i].disc = 1;
        if (gnt) q.push_back('{is_instr: sel_i, disc: sel_i && instr_flush_i});
        if (gnt) m_locked = 0;
        else if (req && !mem_gnt_i && !m_locked) begin
            m_locked = 1; m_owner_instr = sel_i;
        end
        if (!instr_req_i || ig) m_starve = 0;
        else if (dg && m_starve < LIMIT) m_starve++;
        last_ig = ig; last_dg = dg;
    endtask

    initial begin
        logic [31:0] rnd;
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk_all_zero("after_reset");
        @(posedge clk); #1;

        //          ir ia       dr da       mg rv rd       fl  ig dg irv drv mreq maddr    busy
        tbl.push_back(mk(1, 32'h100, 0, 32'h0,   1, 0, 32'h0,  0, 1, 0, 0, 0, 1, 32'h100, 0));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h13, 0, 0, 0, 1, 0, 0, 32'h0,   1));
        tbl.push_back(mk(1, 32'h200, 1, 32'h300, 0, 0, 32'h0,  0, 0, 0, 0, 0, 1, 32'h300, 0));
        tbl.push_back(mk(1, 32'h200, 1, 32'h300, 0, 0, 32'h0,  0, 0, 0, 0, 0, 1, 32'h300, 0));
        tbl.push_back(mk(1, 32'h200, 1, 32'h300, 0, 0, 32'h0,  0, 0, 0, 0, 0, 1, 32'h300, 0));
        tbl.push_back(mk(1, 32'h200, 1, 32'h300, 1, 0, 32'h0,  0, 0, 1, 0, 0, 1, 32'h300, 0));
        tbl.push_back(mk(1, 32'h200, 0, 32'h0,   1, 1, 32'h55, 0, 1, 0, 0, 1, 1, 32'h200, 1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h77, 0, 0, 0, 1, 0, 0, 32'h0,   1));
        tbl.push_back(mk(1, 32'h400, 1, 32'h500, 1, 0, 32'h0,  0, 0, 1, 0, 0, 1, 32'h500, 0));
        tbl.push_back(mk(1, 32'h400, 1, 32'h500, 1, 1, 32'h1,  0, 0, 1, 0, 1, 1, 32'h500, 1));
        tbl.push_back(mk(1, 32'h400, 1, 32'h500, 1, 1, 32'h1,  0, 0, 1, 0, 1, 1, 32'h500, 1));
        tbl.push_back(mk(1, 32'h400, 1, 32'h500, 1, 1, 32'h1,  0, 0, 1, 0, 1, 1, 32'h500, 1));
        tbl.push_back(mk(1, 32'h400, 1, 32'h500, 1, 1, 32'h1,  0, 1, 0, 0, 1, 1, 32'h400, 1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h500, 1, 1, 32'h2,  0, 0, 1, 1, 0, 1, 32'h500, 1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h500, 1, 1, 32'h2,  0, 0, 1, 0, 1, 1, 32'h500, 1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h2,  0, 0, 0, 0, 1, 0, 32'h0,   1));
        tbl.push_back(mk(1, 32'h600, 0, 32'h0,   1, 0, 32'h0,  0, 1, 0, 0, 0, 1, 32'h600, 0));
        tbl.push_back(mk(1, 32'h604, 0, 32'h0,   1, 0, 32'h0,  0, 1, 0, 0, 0, 1, 32'h604, 1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,  1, 0, 0, 0, 0, 0, 32'h0,   1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h9,  0, 0, 0, 0, 0, 0, 32'h0,   1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h9,  0, 0, 0, 0, 0, 0, 32'h0,   1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,   0));
        tbl.push_back(mk(0, 32'h0,   1, 32'h700, 1, 0, 32'h0,  0, 0, 1, 0, 0, 1, 32'h700, 0));
        tbl.push_back(mk(0, 32'h0,   1, 32'h704, 1, 0, 32'h0,  0, 0, 1, 0, 0, 1, 32'h704, 1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h708, 1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,   1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h708, 1, 1, 32'h3,  0, 0, 0, 0, 1, 0, 32'h0,   1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h708, 1, 0, 32'h0,  0, 0, 1, 0, 0, 1, 32'h708, 1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h4,  0, 0, 0, 0, 1, 0, 32'h0,   1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h5,  0, 0, 0, 0, 1, 0, 32'h0,   1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,   0));
        tbl.push_back(mk(1, 32'h800, 0, 32'h0,   1, 0, 32'h0,  0, 1, 0, 0, 0, 1, 32'h800, 0));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h6,  1, 0, 0, 0, 0, 0, 32'h0,   1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,   0));

        foreach (tbl[i]) begin
            instr_req_i = tbl[i].ir; instr_addr_i = tbl[i].ia; instr_flush_i = tbl[i].fl;
            data_req_i = tbl[i].dr; data_addr_i = tbl[i].da;
            mem_gnt_i = tbl[i].mg; mem_rvalid_i = tbl[i].rv; mem_rdata_i = tbl[i].rd;
            @(negedge clk);
            chk($sformatf("row%0d instr_gnt", i), instr_gnt_o, tbl[i].e_ig);
            chk($sformatf("row%0d data_gnt", i), data_gnt_o, tbl[i].e_dg);
            chk($sformatf("row%0d instr_rvalid", i), instr_rvalid_o, tbl[i].e_irv);
            chk($sformatf("row%0d data_rvalid", i), data_rvalid_o, tbl[i].e_drv);
            chk($sformatf("row%0d instr_rdata", i), instr_rdata_o, tbl[i].e_irv ? tbl[i].rd : 32'h0);
            chk($sformatf("row%0d data_rdata", i), data_rdata_o, tbl[i].e_drv ? tbl[i].rd : 32'h0);
            chk($sformatf("row%0d mem_req", i), mem_req_o, tbl[i].e_mreq);
            if (tbl[i].e_mreq) chk($sformatf("row%0d mem_addr", i), mem_addr_o, tbl[i].e_maddr);
            chk($sformatf("row%0d busy", i), busy_o, tbl[i].e_busy);
            @(posedge clk); #1;
        end

        // ---------------- unexpected response ----------------
        idle_inputs();
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("unexp instr_rvalid", instr_rvalid_o, 1'b0);
        chk("unexp data_rvalid", data_rvalid_o, 1'b0);
        chk("unexp data_rdata", data_rdata_o, 32'h0);
        @(posedge clk); #1;
        mem_rvalid_i = 0;
        @(negedge clk);
        chk("unexp sticky set", unexpected_rvalid_o, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("unexp sticky hold", unexpected_rvalid_o, 1'b1);

        // ---------------- reset with a transaction outstanding ----------------
        @(posedge clk); #1;
        instr_req_i = 1; instr_addr_i = 32'h900; mem_gnt_i = 1;
        @(negedge clk);
        chk("rstmid instr_gnt", instr_gnt_o, 1'b1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("rstmid busy before", busy_o, 1'b1);
        @(posedge clk); #1;
        rst = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h1234;
        #2;
        chk("rstmid busy", busy_o, 1'b0);
        chk("rstmid unexpected", unexpected_rvalid_o, 1'b0);
        chk("rstmid instr_rvalid", instr_rvalid_o, 1'b0);
        mem_rvalid_i = 0; mem_rdata_i = 0;
        #1;
        chk_all_zero("rstmid");
        @(posedge clk); #1;
        rst = 0;

        // ---------------- random traffic vs reference model ----------------
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            if (!instr_req_i || last_ig) begin
                instr_req_i = $urandom_range(0, 1);
                rnd = $urandom;
                instr_addr_i = {rnd[31:2], 2'b00};
            end
            if (!data_req_i || last_dg) begin
                data_req_i = ($urandom_range(0, 4) != 0);
                data_we_i = $urandom_range(0, 1);
                data_be_i = 4'($urandom_range(0, 15));
                data_addr_i = $urandom;
                data_wdata_i = $urandom;
            end
            mem_gnt_i = ($urandom_range(0, 9) < 7);
            mem_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i = $urandom;
            mem_err_i = ($urandom_range(0, 7) == 0);
            instr_flush_i = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            model_check_step();
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
